// File: rtl/parity_ram.sv
// Single-port synchronous RAM with one even-parity bit per data byte, a written-location map,
// a parity error counter and a sweep that invalidates every location without a reset.
module parity_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_write,
  input  logic [ADDR_W-1:0]              req_addr,
  input  logic [DATA_W-1:0]              req_wdata,
  input  logic                           inj_err,
  input  logic                           clr,
  output logic                           clr_busy,
  output logic                           rsp_valid,
  output logic [DATA_W+DATA_W/8-1:0]     rsp_data,
  output logic                           rsp_perr,
  output logic                           rsp_unwritten,
  output logic [7:0]                     err_cnt
);

  localparam int NB     = DATA_W / 8;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int WORD_W = DATA_W + NB;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t              state_reg;
  logic [ADDR_W-1:0]   clr_cnt_reg;
  logic                clr_busy_reg;
  logic [DEPTH-1:0]    written_reg;
  logic [WORD_W-1:0]   mem [DEPTH];
  logic [WORD_W-1:0]   rd_word_reg;
  logic                rd_valid_reg;
  logic                rd_hit_reg;
  logic                rd_unw_reg;
  logic [7:0]          err_cnt_reg;

  logic [NB-1:0]       wr_par;
  logic [NB-1:0]       rd_par;
  logic                wr_acc;
  logic                rd_acc;
  logic                clr_start;
  logic [WORD_W-1:0]   s0_data;
  logic                s0_perr;

  assign req_ready = (state_reg == IDLE) && !clr;
  assign wr_acc    = req_valid && req_ready && req_write;
  assign rd_acc    = req_valid && req_ready && !req_write;
  assign clr_start = (state_reg == IDLE) && clr;
  assign clr_busy  = clr_busy_reg;
  assign err_cnt   = err_cnt_reg;

  // Byte 0 parity can be deliberately inverted on write to exercise the checker.
  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_par
      assign wr_par[gi] = (^req_wdata[8*gi +: 8]) ^ ((gi == 0) ? inj_err : 1'b0);
      assign rd_par[gi] = ^rd_word_reg[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[req_addr] <= {wr_par, req_wdata};
    end
    if (rd_acc) begin
      rd_word_reg <= mem[req_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      clr_cnt_reg  <= '0;
      clr_busy_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (clr) begin
            state_reg    <= CLEAR;
            clr_cnt_reg  <= '0;
            clr_busy_reg <= 1'b1;
          end
        end
        CLEAR: begin
          clr_cnt_reg <= clr_cnt_reg + 1'b1;
          if (clr_cnt_reg == {ADDR_W{1'b1}}) begin
            state_reg    <= IDLE;
            clr_busy_reg <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // No request is accepted while sweeping, so the two updates never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      written_reg <= '0;
    end else if (state_reg == CLEAR) begin
      written_reg[clr_cnt_reg] <= 1'b0;
    end else if (wr_acc) begin
      written_reg[req_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_reg <= 1'b0;
      rd_hit_reg   <= 1'b0;
      rd_unw_reg   <= 1'b0;
    end else begin
      rd_valid_reg <= rd_acc;
      if (rd_acc) begin
        rd_hit_reg <= written_reg[req_addr];
        rd_unw_reg <= !written_reg[req_addr];
      end
    end
  end

  assign s0_data = rd_hit_reg ? rd_word_reg : '0;
  assign s0_perr = rd_hit_reg && (rd_par != rd_word_reg[DATA_W +: NB]);

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              rsp_valid_reg;
      logic [WORD_W-1:0] rsp_data_reg;
      logic              rsp_perr_reg;
      logic              rsp_unw_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rsp_valid_reg <= 1'b0;
          rsp_data_reg  <= '0;
          rsp_perr_reg  <= 1'b0;
          rsp_unw_reg   <= 1'b0;
        end else begin
          rsp_valid_reg <= rd_valid_reg;
          if (rd_valid_reg) begin
            rsp_data_reg <= s0_data;
            rsp_perr_reg <= s0_perr;
            rsp_unw_reg  <= rd_unw_reg;
          end
        end
      end

      assign rsp_valid     = rsp_valid_reg;
      assign rsp_data      = rsp_data_reg;
      assign rsp_perr      = rsp_perr_reg;
      assign rsp_unwritten = rsp_unw_reg;
    end else begin : g_lat1
      // Stage registers only load on an accepted read, so outputs hold between responses.
      assign rsp_valid     = rd_valid_reg;
      assign rsp_data      = s0_data;
      assign rsp_perr      = s0_perr;
      assign rsp_unwritten = rd_unw_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_reg <= '0;
    end else if (clr_start) begin
      err_cnt_reg <= '0;
    end else if (rsp_valid && rsp_perr && (err_cnt_reg != 8'hFF)) begin
      err_cnt_reg <= err_cnt_reg + 8'd1;
    end
  end

endmodule
